rr_priority_encoder: RTL and testbench
======================================

# rr_priority_encoder

Registered, parametrised N-to-log2(N) priority encoder with a selectable fixed-priority or round-robin arbitration mode. Each cycle it samples an N-bit request vector and registers the winning index, a one-hot grant and status flags. Results leave through a valid/ready output handshake, so the block can drive a stalling consumer such as a shared-resource controller or display multiplexer. It generalises the combinational 4:2 encoder:

- any width N;
- defined behaviour for multiple or zero active inputs;
- fairness between requesters;
- back-pressure on the output.

## Interface

Parameters:
- N, default 8: number of request lines; legal range 2..256; need not be a power of two.
- IW, default $clog2(N): index width; derived, do not override.
- MODE, default 0: arbitration mode.
  - 0 = fixed priority; the highest index wins.
  - 1 = round-robin.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N  request vector; bit i high means requester i is active.
- out_ready  input  1  consumer can accept the current result.
- out_valid  output  1  idx, grant and multi hold a valid result.
- idx  output  IW  encoded index of the winning requester.
- grant  output  N  one-hot grant; equals 1 << idx when out_valid=1, else all zeros.
- zero  output  1  high when the most recent sample had req == 0.
- multi  output  1  high when the most recent winning sample had two or more req bits set.

## Operation

Capture condition:
- Define load = !out_valid || out_ready.
- Define xfer = out_valid && out_ready.
- On each rising edge with load=1, req is sampled.
  - If req != 0: out_valid<=1, idx<=winner, grant<=onehot(winner), zero<=0, multi<=(popcount(req)>=2).
  - If req == 0: out_valid<=0, grant<=0, zero<=1. idx and multi hold their previous values.
- With load=0 (stall), all outputs hold. Changes on req are ignored; no request is latched.

Winner selection:
- MODE=0: the highest set bit of req wins. The round-robin pointer is unused and stays 0.
- MODE=1: search req upward from the start position s, wrapping from N-1 to 0. The first set bit wins.
  - s = (idx+1) mod N when xfer=1 on this edge; otherwise s = ptr.
  - This rule ensures a requester just granted is not re-granted back-to-back while others are pending.

Round-robin pointer (ptr, IW bits, internal):
- On xfer: ptr <= (idx+1) mod N.
- The wrap is computed modulo N, not modulo 2^IW. With N=5 and idx=4, ptr becomes 0.
- ptr is unchanged when the output stalls or when there is no transfer.
- A lone requester is re-granted every cycle.

Reset (asynchronous, any time including mid-stall) forces:
- out_valid=0, idx=0, grant=0, zero=1, multi=0, ptr=0.

Release of rst_n takes effect at the next rising edge. A pending result is discarded by reset and never delivered.

## Timing

- Latency: req sampled at edge k produces outputs valid immediately after edge k (1 cycle).
- Throughput: one result per cycle while out_ready=1.
- Back-to-back operation: on the same edge, a transfer completes and a new sample loads. ptr updates on that edge.
- The consumer samples idx/grant on the edge where out_valid && out_ready.
- out_valid never drops without a transfer, except on reset.
- idx, grant and multi are stable throughout any cycle with out_valid=1 && out_ready=0.
- No combinational path from req or out_ready to any output; all outputs are registered.

## Test plan

- Reset: assert rst_n=0 mid-stall with out_valid=1 -> outputs are immediately 0/0/0/zero=1/multi=0; after release, req=8'h01 with ready=1 -> idx=0, grant=8'h01.
- Fixed priority (N=8, MODE=0): req=8'b0010_0110 -> next cycle idx=5, grant=8'h20, multi=1, out_valid=1. req=8'h00 -> out_valid=0, zero=1, grant=0.
- Round-robin fairness (N=8, MODE=1): hold req=8'hFF with out_ready=1 for 10 cycles -> idx sequence 0,1,2,3,4,5,6,7,0,1. Then req=8'b1000_0010 after idx=1 -> idx=7, then 1, alternating.
- Back-pressure: with out_valid=1 and idx=3, hold out_ready=0 for 4 cycles while req toggles -> idx stays 3, grant stays 8'h08, and ptr is unchanged. Raise ready -> transfer occurs, and the next winner is searched from 4.
- Non-power-of-two wrap (N=5, MODE=1): req=5'b10001 with ready=1 -> idx 0,4,0,4; after idx=4, ptr=0, never 5.
- Single requester: req=8'h10 held in MODE=1 -> idx=4 every cycle, multi=0, out_valid continuously 1.

Source files
------------

// File: rtl/rr_priority_encoder.sv
// ---------------------------------------------------------------------------
// rr_priority_encoder
//
// Registered N-to-log2(N) priority encoder with a selectable arbitration
// mode. Each accepted cycle samples the request vector and registers the
// winning index, a one-hot grant and status flags. Results leave through a
// valid/ready handshake, so a stalling consumer simply holds out_ready low
// and the current result stays frozen until it is taken.
//
// Parameters:
//   N     number of request lines (2..256, any value, not only powers of 2)
//   IW    index width, derived from N; leave at its default
//   MODE  0 = fixed priority (highest index wins)
//         1 = round-robin (search upward from a rotating start position)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req        in   [N-1:0] request vector, bit i = requester i active
//   out_ready  in   consumer can accept the current result
//   out_valid  out  idx / grant / multi hold a valid result
//   idx        out  [IW-1:0] index of the winning requester
//   grant      out  [N-1:0] one-hot grant, all zeros when out_valid = 0
//   zero       out  most recent sample had no request bits set
//   multi      out  most recent winning sample had two or more bits set
// ---------------------------------------------------------------------------
module rr_priority_encoder #(
  parameter int N    = 8,
  parameter int IW   = $clog2(N),
  parameter int MODE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  grant,
  output logic          zero,
  output logic          multi
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  logic          load;
  logic          xfer;
  logic [IW-1:0] idx_succ;
  logic [IW-1:0] start;
  logic [IW-1:0] ptr;
  logic [IW-1:0] fixed_win;
  logic [IW-1:0] rr_win;
  logic          rr_found;
  logic [IW-1:0] winner;
  logic [N-1:0]  winner_onehot;
  logic          any_req;
  logic          many_req;
  int            pos;

  // A new sample is taken whenever the output register is empty or is being
  // drained on this same edge; a transfer is the consumer taking the result.
  assign load = !out_valid || out_ready;
  assign xfer = out_valid && out_ready;

  // Successor of the current index, wrapping at N rather than at 2^IW so
  // that non-power-of-two widths never point at a requester that does not
  // exist.
  assign idx_succ = (idx == LAST_IDX) ? '0 : idx + IW'(1);

  // The round-robin search starts just past the requester that is being
  // handed over on this edge; the pointer register only carries that
  // position across cycles where nothing was transferred (for example
  // after an idle cycle dropped out_valid).
  assign start = xfer ? idx_succ : ptr;

  assign any_req  = |req;
  assign many_req = |(req & (req - N'(1)));

  // Fixed priority: scanning upward and overwriting leaves the highest set
  // bit as the winner.
  always_comb begin
    fixed_win = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        fixed_win = IW'(i);
      end
    end
  end

  // Round-robin: walk all N positions starting at 'start', wrapping back
  // to 0 after N-1, and keep the first active requester encountered.
  always_comb begin
    rr_win   = '0;
    rr_found = 1'b0;
    pos      = 0;
    for (int k = 0; k < N; k++) begin
      pos = int'(start) + k;
      if (pos >= N) begin
        pos = pos - N;
      end
      if (!rr_found && req[pos]) begin
        rr_win   = IW'(pos);
        rr_found = 1'b1;
      end
    end
  end

  assign winner        = (MODE == 1) ? rr_win : fixed_win;
  assign winner_onehot = N'(1) << winner;

  // Output result register. On an empty sample the index and multi flag
  // keep their last winning values; only valid, grant and zero change.
  // While stalled nothing moves, so the consumer sees a stable result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      idx       <= '0;
      grant     <= '0;
      zero      <= 1'b1;
      multi     <= 1'b0;
    end else if (load) begin
      if (any_req) begin
        out_valid <= 1'b1;
        idx       <= winner;
        grant     <= winner_onehot;
        zero      <= 1'b0;
        multi     <= many_req;
      end else begin
        out_valid <= 1'b0;
        grant     <= '0;
        zero      <= 1'b1;
      end
    end
  end

  // Round-robin pointer. It advances only when a result is actually
  // handed over, so stalls never skip anyone. In fixed-priority mode it
  // stays parked at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if ((MODE == 1) && xfer) begin
      ptr <= idx_succ;
    end
  end

endmodule

// File: tb/tb_rr_priority_encoder.sv
// ---------------------------------------------------------------------------
// tb_rr_priority_encoder
//
// Directed bench for rr_priority_encoder. Three instances share one clock
// and reset: an 8-wide fixed-priority encoder, an 8-wide round-robin
// encoder and a 5-wide round-robin encoder for the non-power-of-two wrap.
// Expected values below are worked out by hand from the arbitration rules.
// ---------------------------------------------------------------------------
module tb_rr_priority_encoder;

  logic       clk;
  logic       rst_n;

  logic [7:0] fp_req;
  logic       fp_ready;
  logic       fp_valid;
  logic [2:0] fp_idx;
  logic [7:0] fp_grant;
  logic       fp_zero;
  logic       fp_multi;

  logic [7:0] rr_req;
  logic       rr_ready;
  logic       rr_valid;
  logic [2:0] rr_idx;
  logic [7:0] rr_grant;
  logic       rr_zero;
  logic       rr_multi;

  logic [4:0] w5_req;
  logic       w5_ready;
  logic       w5_valid;
  logic [2:0] w5_idx;
  logic [4:0] w5_grant;
  logic       w5_zero;
  logic       w5_multi;

  int checks;
  int passes;
  int fails;

  rr_priority_encoder #(.N(8), .MODE(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req(fp_req), .out_ready(fp_ready),
    .out_valid(fp_valid), .idx(fp_idx), .grant(fp_grant),
    .zero(fp_zero), .multi(fp_multi)
  );

  rr_priority_encoder #(.N(8), .MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req(rr_req), .out_ready(rr_ready),
    .out_valid(rr_valid), .idx(rr_idx), .grant(rr_grant),
    .zero(rr_zero), .multi(rr_multi)
  );

  rr_priority_encoder #(.N(5), .MODE(1)) dut_w5 (
    .clk(clk), .rst_n(rst_n), .req(w5_req), .out_ready(w5_ready),
    .out_valid(w5_valid), .idx(w5_idx), .grant(w5_grant),
    .zero(w5_zero), .multi(w5_multi)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: count it and report any difference.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      passes++;
    end
  endtask

  // Drive one instance's inputs: 0 = fixed 8-wide, 1 = rr 8-wide, 2 = rr 5-wide.
  task automatic applyStimulus(input int which, input logic [7:0] r,
                               input logic rdy);
    case (which)
      0: begin fp_req = r;      fp_ready = rdy; end
      1: begin rr_req = r;      rr_ready = rdy; end
      default: begin w5_req = r[4:0]; w5_ready = rdy; end
    endcase
  endtask

  // Advance one clock and land 1 unit past the edge, where outputs are sampled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Guard against any hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [7:0] bp_reqs [4];
  logic [2:0] exp_idx;

  initial begin
    checks = 0; passes = 0; fails = 0;
    rst_n = 1'b0;
    applyStimulus(0, 8'h00, 1'b0);
    applyStimulus(1, 8'h00, 1'b0);
    applyStimulus(2, 8'h00, 1'b0);
    bp_reqs[0] = 8'hFF; bp_reqs[1] = 8'h01;
    bp_reqs[2] = 8'h00; bp_reqs[3] = 8'h40;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", 32'(fp_valid), 32'd0);
    checkOutput("rst_idx",   32'(fp_idx),   32'd0);
    checkOutput("rst_grant", 32'(fp_grant), 32'd0);
    checkOutput("rst_zero",  32'(fp_zero),  32'd1);
    checkOutput("rst_multi", 32'(fp_multi), 32'd0);
    checkOutput("rst_w5_zero", 32'(w5_zero), 32'd1);
    rst_n = 1'b1;

    // Load a result, stall it, then reset asynchronously mid-stall.
    applyStimulus(0, 8'h0C, 1'b1);
    step();
    checkOutput("pre_rst_valid", 32'(fp_valid), 32'd1);
    checkOutput("pre_rst_idx",   32'(fp_idx),   32'd3);
    checkOutput("pre_rst_multi", 32'(fp_multi), 32'd1);
    applyStimulus(0, 8'h01, 1'b0);
    step();
    checkOutput("stall_idx", 32'(fp_idx), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(fp_valid), 32'd0);
    checkOutput("async_rst_idx",   32'(fp_idx),   32'd0);
    checkOutput("async_rst_grant", 32'(fp_grant), 32'd0);
    checkOutput("async_rst_zero",  32'(fp_zero),  32'd1);
    checkOutput("async_rst_multi", 32'(fp_multi), 32'd0);
    step();
    rst_n = 1'b1;
    applyStimulus(0, 8'h01, 1'b1);
    step();
    checkOutput("post_rst_idx",   32'(fp_idx),   32'd0);
    checkOutput("post_rst_grant", 32'(fp_grant), 32'h01);
    checkOutput("post_rst_valid", 32'(fp_valid), 32'd1);

    // Fixed priority: highest set bit wins, every time.
    applyStimulus(0, 8'b0010_0110, 1'b1);
    step();
    checkOutput("fp_idx",   32'(fp_idx),   32'd5);
    checkOutput("fp_grant", 32'(fp_grant), 32'h20);
    checkOutput("fp_multi", 32'(fp_multi), 32'd1);
    checkOutput("fp_valid", 32'(fp_valid), 32'd1);
    checkOutput("fp_zero",  32'(fp_zero),  32'd0);
    applyStimulus(0, 8'h00, 1'b1);
    step();
    checkOutput("fp_empty_valid", 32'(fp_valid), 32'd0);
    checkOutput("fp_empty_zero",  32'(fp_zero),  32'd1);
    checkOutput("fp_empty_grant", 32'(fp_grant), 32'd0);
    checkOutput("fp_empty_idx_hold",   32'(fp_idx),   32'd5);
    checkOutput("fp_empty_multi_hold", 32'(fp_multi), 32'd1);
    applyStimulus(0, 8'h81, 1'b1);
    step();
    checkOutput("fp_top_idx", 32'(fp_idx), 32'd7);
    step();
    checkOutput("fp_top_again_idx", 32'(fp_idx), 32'd7);

    // Round-robin with everyone requesting: visit 0..7 then wrap.
    applyStimulus(1, 8'hFF, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      exp_idx = 3'(i % 8);
      checkOutput($sformatf("rr_all_idx%0d", i), 32'(rr_idx), 32'(exp_idx));
    end
    checkOutput("rr_all_grant", 32'(rr_grant), 32'h02);

    // Two requesters alternate fairly.
    applyStimulus(1, 8'b1000_0010, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      exp_idx = (i % 2 == 0) ? 3'd7 : 3'd1;
      checkOutput($sformatf("rr_pair_idx%0d", i), 32'(rr_idx), 32'(exp_idx));
    end

    // A lone requester is granted every cycle.
    applyStimulus(1, 8'h10, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput($sformatf("rr_single_idx%0d", i), 32'(rr_idx), 32'd4);
      checkOutput($sformatf("rr_single_valid%0d", i), 32'(rr_valid), 32'd1);
    end
    checkOutput("rr_single_multi", 32'(rr_multi), 32'd0);

    // Back-pressure: result with idx 3 held while req changes underneath.
    applyStimulus(1, 8'h08, 1'b1);
    step();
    checkOutput("bp_load_idx", 32'(rr_idx), 32'd3);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, bp_reqs[i], 1'b0);
      step();
      checkOutput($sformatf("bp_idx%0d", i),   32'(rr_idx),   32'd3);
      checkOutput($sformatf("bp_grant%0d", i), 32'(rr_grant), 32'h08);
      checkOutput($sformatf("bp_valid%0d", i), 32'(rr_valid), 32'd1);
    end
    applyStimulus(1, 8'h30, 1'b1);
    step();
    checkOutput("bp_release_idx", 32'(rr_idx), 32'd4);
    applyStimulus(1, 8'h00, 1'b1);
    step();
    checkOutput("rr_idle_valid", 32'(rr_valid), 32'd0);
    checkOutput("rr_idle_zero",  32'(rr_zero),  32'd1);
    applyStimulus(1, 8'h31, 1'b1);
    step();
    checkOutput("rr_ptr_resume_idx", 32'(rr_idx), 32'd5);

    // Five-wide round-robin: wrap from 4 back to 0.
    applyStimulus(2, 8'h11, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      exp_idx = (i % 2 == 0) ? 3'd0 : 3'd4;
      checkOutput($sformatf("w5_idx%0d", i), 32'(w5_idx), 32'(exp_idx));
    end
    checkOutput("w5_grant", 32'(w5_grant), 32'h10);
    applyStimulus(2, 8'h00, 1'b1);
    step();
    checkOutput("w5_idle_valid", 32'(w5_valid), 32'd0);
    applyStimulus(2, 8'h18, 1'b1);
    step();
    checkOutput("w5_ptr_wrap_idx", 32'(w5_idx), 32'd3);
    applyStimulus(2, 8'h11, 1'b1);
    step();
    checkOutput("w5_after3_idx", 32'(w5_idx), 32'd4);
    step();
    checkOutput("w5_wrap_idx", 32'(w5_idx), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
